// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared constants and helpers for the multi-cycle RV32I core.
//                DATA_ADDR_SIZE - default byte-address width of data memory
//                WORD_BYTES     - bytes per 32-bit word
//                word_index()   - byte address -> word index, wrapped to the
//                                 memory capacity
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  parameter int DATA_ADDR_SIZE = 10;
  localparam int WORD_BYTES = 4;

  // Drops the bits above the memory capacity (address wrap) and the byte
  // offset within the word (accesses are always treated as aligned).
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input int          addr_size);
    logic [31:0] mask;
    mask = (32'd1 << addr_size) - 32'd1;
    return (addr & mask) >> $clog2(WORD_BYTES);
  endfunction

endpackage : core_pkg
`default_nettype wire

// File: rtl/memory_data.sv
`default_nettype none
// ============================================================================
//  Module      : memory_data
//  Description : Data memory of the multi-cycle RV32I core. Byte-addressed,
//                word-organised RAM with a combinational read port and a
//                synchronous full-word write port. Asynchronous reset clears
//                the whole array.
//  Ports       : clk          - clock, writes on rising edge
//                rst          - async active-high reset, clears every word
//                read_addr    - byte address of the word to read
//                read_data    - word at read_addr (combinational)
//                write_addr   - byte address of the word to write
//                write_data   - full 32-bit word to store
//                write_enable - store strobe, sampled at rising clk
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_data
  import core_pkg::*;
#(
  parameter int ADDR_SIZE = DATA_ADDR_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] read_addr,
  output logic [31:0] read_data,
  input  logic [31:0] write_addr,
  input  logic [31:0] write_data,
  input  logic        write_enable
);

  localparam int IDX_BITS = ADDR_SIZE - 2;
  localparam int DEPTH    = 2 ** IDX_BITS;

  logic [31:0] mem_q [0:DEPTH-1];
  logic [31:0] mem_d [0:DEPTH-1];

  logic [31:0]         w_rd_idx_full;
  logic [31:0]         w_wr_idx_full;
  logic [IDX_BITS-1:0] w_rd_idx;
  logic [IDX_BITS-1:0] w_wr_idx;

  assign w_rd_idx_full = word_index(read_addr, ADDR_SIZE);
  assign w_wr_idx_full = word_index(write_addr, ADDR_SIZE);
  assign w_rd_idx      = w_rd_idx_full[IDX_BITS-1:0];
  assign w_wr_idx      = w_wr_idx_full[IDX_BITS-1:0];

  // Upper index bits are always zero after word_index() masks the address.
  logic unused_idx_bits;
  assign unused_idx_bits = ^{w_rd_idx_full[31:IDX_BITS], w_wr_idx_full[31:IDX_BITS]};

  // Next array contents: hold, or replace one whole word on a store.
  // SB/SH arrive pre-extended, so there are no byte strobes.
  always_comb begin
    mem_d = mem_q;
    if (write_enable) begin
      mem_d[w_wr_idx] = write_data;
    end
  end

  // Reset takes priority over a same-cycle store, discarding it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // No bypass: a read of the word being written shows the old value until
  // the clock edge commits the store.
  assign read_data = mem_q[w_rd_idx];

endmodule : memory_data
`default_nettype wire

// File: tb/tb_memory_data.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_data
//  Description : Directed self-checking bench for memory_data.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_data;

  logic        clk;
  logic        rst;
  logic [31:0] read_addr;
  logic [31:0] read_data;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic        write_enable;

  int checks   = 0;
  int failures = 0;

  memory_data #(.ADDR_SIZE(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    read_addr = addr;
    #1;
    check(tag, read_data, exp);
  endtask

  // One store committed on the rising edge between two falling edges.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    write_addr   = addr;
    write_data   = data;
    write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    read_addr    = 32'h0;
    write_addr   = 32'h4;
    write_data   = 32'hFFFF_FFFF;
    write_enable = 1'b1;

    // Reset clear: stores attempted under reset are dropped.
    repeat (3) @(negedge clk);
    write_addr = 32'h0;
    @(negedge clk);
    write_enable = 1'b0;
    rst          = 1'b0;
    read_check("reset_0x000", 32'h000, 32'h0);
    read_check("reset_0x004", 32'h004, 32'h0);
    read_check("reset_0x3FC", 32'h3FC, 32'h0);

    // Write then read, low address bits ignored.
    do_write(32'h010, 32'hDEAD_BEEF);
    read_check("wr_rd_0x010", 32'h010, 32'hDEAD_BEEF);
    read_check("wr_rd_0x013", 32'h013, 32'hDEAD_BEEF);

    // Wrap-around modulo 2**10 bytes.
    do_write(32'h404, 32'h1234_5678);
    read_check("wrap_0x004", 32'h004, 32'h1234_5678);
    read_check("wrap_0x804", 32'h804, 32'h1234_5678);
    read_check("wrap_0x3FC_untouched", 32'h3FC, 32'h0);

    // Read-during-write: old word before the edge, new word after.
    do_write(32'h020, 32'h0000_0001);
    @(negedge clk);
    write_addr   = 32'h020;
    write_data   = 32'h0000_0002;
    write_enable = 1'b1;
    read_check("rdw_before_edge", 32'h020, 32'h0000_0001);
    @(posedge clk);
    #1;
    check("rdw_after_edge", read_data, 32'h0000_0002);
    @(negedge clk);
    write_enable = 1'b0;

    // Write disabled over three edges.
    write_addr = 32'h030;
    write_data = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    read_check("we0_0x030", 32'h030, 32'h0);
    read_check("we0_0x010_kept", 32'h010, 32'hDEAD_BEEF);

    // Asynchronous reset priority, mid-cycle.
    do_write(32'h040, 32'hA5A5_A5A5);
    read_check("pre_rst_0x040", 32'h040, 32'hA5A5_A5A5);
    write_addr   = 32'h040;
    write_data   = 32'h1111_1111;
    write_enable = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_0x040", read_data, 32'h0);
    read_check("async_rst_0x010", 32'h010, 32'h0);
    @(posedge clk);
    #1;
    read_check("rst_over_we_0x040", 32'h040, 32'h0);
    @(negedge clk);
    write_enable = 1'b0;
    rst          = 1'b0;
    @(negedge clk);
    read_check("post_rst_0x040", 32'h040, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_memory_data
`default_nettype wire
